// File: rtl/crypto_stream_pkg.sv
// Shared definitions for the crypto_stream nibble cipher.
//   mode_e        : beat mode (MODE_ENC = 0, MODE_DEC = 1)
//   DEFAULT_TAPS  : default LFSR feedback mask
//   DEFAULT_SEED  : default LFSR reset / fallback value
//   sbox_fwd/inv  : 4-bit substitution and its exact inverse
package crypto_stream_pkg;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    localparam logic [7:0] DEFAULT_TAPS = 8'hF8;
    localparam logic [7:0] DEFAULT_SEED = 8'hAC;

    function automatic logic [3:0] sbox_fwd(input logic [3:0] n);
        logic [3:0] r;
        case (n)
            4'h0: r = 4'h6;  4'h1: r = 4'h4;  4'h2: r = 4'hC;  4'h3: r = 4'h5;
            4'h4: r = 4'h0;  4'h5: r = 4'h7;  4'h6: r = 4'h2;  4'h7: r = 4'hE;
            4'h8: r = 4'h1;  4'h9: r = 4'hF;  4'hA: r = 4'h3;  4'hB: r = 4'hD;
            4'hC: r = 4'h8;  4'hD: r = 4'hA;  4'hE: r = 4'h9;  default: r = 4'hB;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] n);
        logic [3:0] r;
        case (n)
            4'h0: r = 4'h4;  4'h1: r = 4'h8;  4'h2: r = 4'h6;  4'h3: r = 4'hA;
            4'h4: r = 4'h1;  4'h5: r = 4'h3;  4'h6: r = 4'h0;  4'h7: r = 4'h5;
            4'h8: r = 4'hC;  4'h9: r = 4'hE;  4'hA: r = 4'hD;  4'hB: r = 4'hF;
            4'hC: r = 4'h2;  4'hD: r = 4'hB;  4'hE: r = 4'h7;  default: r = 4'h9;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/crypto_stream_keygen.sv
// Key generator: Fibonacci-style LFSR supplying one key per accepted beat,
// plus the 16-bit accepted-beat counter.
//   clk, rst   : clock / synchronous active-high reset
//   advance    : a beat is accepted this cycle (step LFSR, bump counter)
//   seed_load  : reload LFSR from seed_in (SEED when seed_in is zero)
//   seed_in    : new LFSR value
//   key        : current LFSR value, the key for a beat accepted this cycle
//   beat_cnt   : accepted-beat count, wraps, untouched by seed loads
module crypto_stream_keygen
    import crypto_stream_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] TAPS   = DATA_W'(DEFAULT_TAPS),
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(DEFAULT_SEED)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              seed_load,
    input  logic [DATA_W-1:0] seed_in,
    output logic [DATA_W-1:0] key,
    output logic [15:0]       beat_cnt
);

    logic [DATA_W-1:0] lfsr_q, lfsr_d;
    logic [15:0]       cnt_q, cnt_d;

    always_comb begin
        lfsr_d = lfsr_q;
        cnt_d  = cnt_q;
        // advance is never high together with seed_load (in_ready is low),
        // so the seed simply wins here.
        if (seed_load) begin
            // An all-zero LFSR would lock up; fall back to SEED instead.
            lfsr_d = (seed_in == '0) ? SEED : seed_in;
        end else if (advance) begin
            lfsr_d = {lfsr_q[DATA_W-2:0], ^(lfsr_q & TAPS)};
        end
        if (advance) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
            cnt_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign key      = lfsr_q;
    assign beat_cnt = cnt_q;

endmodule

// File: rtl/crypto_stream.sv
// Two-stage streaming nibble cipher with an LFSR key stream.
//   encrypt: S(rotl1(x ^ k))      decrypt: rotr1(Sinv(y)) ^ k
// Stage 1 does rotl1(x^k) / Sinv(y); stage 2 does S(t) / rotr1(t)^k.
//   clk, rst              : clock / synchronous active-high reset
//   seed_load, seed_in    : reload the key LFSR (blocks acceptance that cycle)
//   in_valid/in_ready     : input handshake, in_mode/in_data the beat
//   out_valid/out_ready   : output handshake, out_data/out_mode the result
//   beat_cnt              : number of accepted input beats (wrapping)
module crypto_stream
    import crypto_stream_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] TAPS   = DATA_W'(DEFAULT_TAPS),
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(DEFAULT_SEED)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [DATA_W-1:0] seed_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_mode,
    output logic [15:0]       beat_cnt
);

    localparam int NIBBLES = DATA_W / 4;

    logic              s1_valid_q, s1_mode_q;
    logic [DATA_W-1:0] s1_val_q, s1_key_q;
    logic              s2_valid_q, s2_mode_q;
    logic [DATA_W-1:0] s2_val_q;

    logic [DATA_W-1:0] key;
    logic [DATA_W-1:0] mix, in_sinv, s1_sfwd;
    logic [DATA_W-1:0] s1_val_d, s2_val_d;
    logic              s2_adv, s1_en, accept;

    // Stage 2 moves when empty or being drained; stage 1 may load whenever
    // its contents can move on, giving full rate with no bubbles.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_adv;
    assign in_ready = !rst && !seed_load && s1_en;
    assign accept   = in_valid && in_ready;

    crypto_stream_keygen #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_keygen (
        .clk       (clk),
        .rst       (rst),
        .advance   (accept),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .key       (key),
        .beat_cnt  (beat_cnt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign in_sinv[gi*4 +: 4] = sbox_inv(in_data[gi*4 +: 4]);
            assign s1_sfwd[gi*4 +: 4] = sbox_fwd(s1_val_q[gi*4 +: 4]);
        end
    endgenerate

    assign mix      = in_data ^ key;
    assign s1_val_d = (in_mode == MODE_DEC) ? in_sinv
                                            : {mix[DATA_W-2:0], mix[DATA_W-1]};
    assign s2_val_d = (s1_mode_q == MODE_DEC)
                    ? ({s1_val_q[0], s1_val_q[DATA_W-1:1]} ^ s1_key_q)
                    : s1_sfwd;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_val_q   <= '0;
            s1_key_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_mode_q  <= 1'b0;
            s2_val_q   <= '0;
        end else begin
            if (s1_en) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_mode_q <= in_mode;
                    s1_val_q  <= s1_val_d;
                    // Key is captured here so a later seed load cannot
                    // affect a beat already in flight.
                    s1_key_q  <= key;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                // Payload only updates on a real beat, so out_data keeps its
                // last value rather than picking up stale stage-1 contents.
                if (s1_valid_q) begin
                    s2_mode_q <= s1_mode_q;
                    s2_val_q  <= s2_val_d;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_val_q;
    assign out_mode  = s2_mode_q;

endmodule

// File: tb/tb_crypto_stream.sv
// Self-checking bench for crypto_stream (DATA_W=8, default TAPS/SEED).
module tb_crypto_stream;

    logic        clk = 1'b0;
    logic        rst, seed_load, in_valid, in_mode, out_ready;
    logic [7:0]  seed_in, in_data;
    logic        in_ready, out_valid, out_mode;
    logic [7:0]  out_data;
    logic [15:0] beat_cnt;

    always #5 clk = ~clk;

    crypto_stream dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .beat_cnt  (beat_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] sb [16] = '{4'h6, 4'h4, 4'hC, 4'h5, 4'h0, 4'h7, 4'h2, 4'hE,
                            4'h1, 4'hF, 4'h3, 4'hD, 4'h8, 4'hA, 4'h9, 4'hB};
    logic [3:0] sb_inv [16];

    typedef struct {
        logic [7:0] res;
        logic       mode;
        int         acc;
    } item_t;

    item_t      mq[$];
    logic [8:0] obs[$];
    logic [7:0] m_lfsr = 8'hAC;
    logic [15:0] m_cnt = 16'd0;
    int         cyc = 0;

    function automatic logic [7:0] rotl(input logic [7:0] v);
        int t = int'(v);
        return 8'(((t << 1) | (t >> 7)) & 255);
    endfunction

    function automatic logic [7:0] rotr(input logic [7:0] v);
        int t = int'(v);
        return 8'(((t >> 1) | (t << 7)) & 255);
    endfunction

    function automatic logic [7:0] subst(input logic [7:0] v, input bit inv);
        logic [3:0] hi = v[7:4];
        logic [3:0] lo = v[3:0];
        if (inv) return {sb_inv[hi], sb_inv[lo]};
        return {sb[hi], sb[lo]};
    endfunction

    function automatic logic [7:0] cipher(input logic m, input logic [7:0] d, input logic [7:0] k);
        if (m) return rotr(subst(d, 1'b1)) ^ k;
        return subst(rotl(d ^ k), 1'b0);
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hF8)};
    endfunction

    // Compare process: checks at the falling edge, advances the model at the rising edge.
    initial begin : model
        bit exp_rdy, exp_ov;
        for (int i = 0; i < 16; i++) sb_inv[sb[i]] = 4'(i);
        forever begin
            @(negedge clk);
            exp_rdy = !rst && !seed_load && (mq.size() < 2 || out_ready);
            exp_ov  = mq.size() > 0 && (cyc - mq[0].acc >= 1);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
            if (exp_ov) begin
                chk("out_data", 32'(out_data), 32'(mq[0].res));
                chk("out_mode", 32'(out_mode), 32'(mq[0].mode));
            end
            if (!rst && out_valid && out_ready) obs.push_back({out_mode, out_data});
            @(posedge clk);
            cyc++;
            if (rst) begin
                mq.delete();
                m_lfsr = 8'hAC;
                m_cnt  = 16'd0;
            end else begin
                if (exp_ov && out_ready) void'(mq.pop_front());
                if (in_valid && exp_rdy) begin
                    mq.push_back('{res: cipher(in_mode, in_data, m_lfsr), mode: in_mode, acc: cyc});
                    m_lfsr = lfsr_step(m_lfsr);
                    m_cnt  = m_cnt + 16'd1;
                end
                if (seed_load) m_lfsr = (seed_in != 8'h00) ? seed_in : 8'hAC;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic m, input logic [7:0] d, input bit rand_ready);
        bit a;
        int t = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        do begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            a = in_ready;
            @(posedge clk);
            #2;
            t++;
        end while (!a && t < 50);
        if (!a) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no accept required accept within 50 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, input logic [7:0] d, input logic m);
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_data"}, 32'(out_data), 32'(d));
        chk({name, "_mode"}, 32'(out_mode), 32'(m));
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int t = 0;
        out_ready = 1'b1;
        while (mq.size() != 0 && t < 20) begin
            tick();
            t++;
        end
        chk("drain_empty", 32'(mq.size()), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    logic [7:0] pt [256];
    logic [7:0] ct [256];
    logic [7:0] sd [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin : main
        bit a;
        int k, t, base;
        rst = 1'b1; seed_load = 1'b0; seed_in = 8'h00;
        in_valid = 1'b0; in_mode = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        repeat (3) tick();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_beat_cnt", 32'(beat_cnt), 32'd0);
        rst = 1'b0;

        // Back-to-back encrypt of 0x00, 0x00.
        in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h00;
        tick(); tick();
        in_valid = 1'b0;
        wait_out("enc0", 8'h7F, 1'b0);
        wait_out("enc1", 8'hDC, 1'b0);
        chk("enc_beat_cnt", 32'(beat_cnt), 32'd2);

        // Decrypt them back.
        do_reset();
        in_valid = 1'b1; in_mode = 1'b1; in_data = 8'h7F;
        tick();
        in_data = 8'hDC;
        tick();
        in_valid = 1'b0;
        wait_out("dec0", 8'h00, 1'b1);
        wait_out("dec1", 8'h00, 1'b1);

        // Seed load with zero falls back to SEED and blocks acceptance.
        seed_load = 1'b1; seed_in = 8'h00;
        in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h00;
        @(negedge clk);
        chk("seed_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #2;
        seed_load = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_out("seed0", 8'h7F, 1'b0);
        send(1'b0, 8'h00, 1'b0);
        drain();
        seed_load = 1'b1; seed_in = 8'h59;
        tick();
        seed_load = 1'b0;
        send(1'b0, 8'h00, 1'b0);
        wait_out("seed59", 8'hDC, 1'b0);

        // Stall: out_ready low for 3 cycles with beats offered.
        drain();
        base = obs.size();
        out_ready = 1'b0;
        k = 0;
        in_valid = 1'b1; in_mode = 1'b0; in_data = sd[0];
        repeat (3) begin
            @(negedge clk);
            a = in_ready;
            @(posedge clk); #2;
            if (a) begin k++; in_data = sd[k]; end
        end
        chk("stall_accepts", 32'(k), 32'd2);
        out_ready = 1'b1;
        t = 0;
        while (k < 3 && t < 20) begin
            @(negedge clk);
            a = in_ready;
            @(posedge clk); #2;
            if (a) begin k++; in_data = sd[k]; end
            t++;
        end
        in_valid = 1'b0;
        drain();
        chk("stall_out_count", 32'(obs.size() - base), 32'd3);

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h5A;
        tick(); tick();
        in_valid = 1'b0;
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_full_out_valid", 32'(out_valid), 32'd0);
        chk("rst_full_beat_cnt", 32'(beat_cnt), 32'd0);
        @(posedge clk); #2;
        send(1'b0, 8'h00, 1'b0);
        wait_out("rst_full_enc", 8'h7F, 1'b0);

        // 256-byte round trip.
        do_reset();
        obs.delete();
        for (int i = 0; i < 256; i++) begin
            pt[i] = 8'($urandom);
            send(1'b0, pt[i], 1'b1);
        end
        drain();
        chk("rt_ct_count", 32'(obs.size()), 32'd256);
        for (int i = 0; i < 256; i++) ct[i] = (i < obs.size()) ? obs[i][7:0] : 8'h00;
        do_reset();
        obs.delete();
        for (int i = 0; i < 256; i++) send(1'b1, ct[i], 1'b1);
        drain();
        chk("rt_pt_count", 32'(obs.size()), 32'd256);
        for (int i = 0; i < 256 && i < obs.size(); i++)
            chk("rt_plain", 32'(obs[i][7:0]), 32'(pt[i]));

        // Random traffic with seed loads and resets.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            seed_load = ($urandom_range(0, 15) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            in_valid  = 1'($urandom_range(0, 1));
            in_mode   = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0; seed_load = 1'b0; in_valid = 1'b0;
        drain();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crypto_stream.md
CRYPTO_STREAM -- requirements
Module: crypto_stream

Interface
REQ-001 Parameter DATA_W, default 8: data, key and LFSR width; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter TAPS, default 8'hF8: LFSR feedback mask, DATA_W bits wide.
REQ-003 Parameter SEED, default 8'hAC: LFSR reset and fallback value, DATA_W bits wide, nonzero.
REQ-004 Ports are clk, in, 1, the single clock; all logic SHALL be on its rising edge.
REQ-005 Ports are rst, in, 1, synchronous active-high reset.
REQ-006 seed_load, in, 1: load seed_in into the LFSR.
REQ-007 seed_in, in, DATA_W: seed value.
REQ-008 in_valid / in_ready, in / out, 1 each: input handshake.
REQ-009 in_mode, in, 1: 0 = encrypt, 1 = decrypt.
REQ-010 in_data, in, DATA_W: plaintext or ciphertext.
REQ-011 out_valid / out_ready, out / in, 1 each: output handshake.
REQ-012 out_data, out, DATA_W: result.
REQ-013 out_mode, out, 1: mode of the beat on out_data.
REQ-014 beat_cnt, out, 16: count of accepted input beats.

Function
REQ-015 A beat SHALL be accepted on a cycle where in_valid=1 and in_ready=1.
REQ-016 The key for a beat SHALL be the LFSR value in its accept cycle; the LFSR SHALL advance exactly once per accepted beat, as lfsr <= {lfsr[DATA_W-2:0], ^(lfsr & TAPS)}.
REQ-017 Encrypt SHALL compute S(rotl1(x ^ k)), where S is applied per nibble.
REQ-018 Decrypt SHALL compute rotr1(Sinv(y)) ^ k.
REQ-019 S SHALL map 0..F to 6,4,C,5,0,7,2,E,1,F,3,D,8,A,9,B, and Sinv SHALL be its exact inverse.
REQ-020 The block SHALL be a two-stage pipeline; each stage carries valid, mode, an intermediate value and the key.
REQ-021 Stage 1 SHALL compute rotl1(x^k) for encrypt and Sinv(y) for decrypt.
REQ-022 Stage 2 SHALL compute S(t) for encrypt and rotr1(t)^k for decrypt.
REQ-023 Latency SHALL be 2 cycles from accept to out_valid when there is no stall; throughput SHALL be 1 beat per cycle.
REQ-024 Stage 2 SHALL hold when out_valid=1 and out_ready=0; out_data and out_mode SHALL stay stable while held.
REQ-025 Stage 1 SHALL advance only when stage 2 is empty or draining.
REQ-026 in_ready SHALL equal !seed_load && (!s1_valid || s2 advancing), i.e. full-rate backpressure with no bubbles.
REQ-027 On seed_load=1 the LFSR SHALL take seed_in, or SEED if seed_in is 0, on the next edge.
REQ-028 in_ready SHALL be 0 in a seed_load cycle, so seed_load takes priority over acceptance.
REQ-029 In-flight beats SHALL keep their captured keys across a seed load.
REQ-030 beat_cnt SHALL increment per accepted beat and wrap from 0xFFFF to 0; seed_load SHALL NOT clear it.

Reset
REQ-031 On rst=1 at a clock edge: lfsr=SEED, both stage valids=0, out_valid=0, out_data=0, out_mode=0, beat_cnt=0.
REQ-032 in_ready SHALL be 0 during a reset cycle and 1 on the first cycle after reset.
REQ-033 Reset mid-operation SHALL discard in-flight beats with no output; rst SHALL have priority over seed_load and the handshakes.

Structure
REQ-034 Package crypto_stream_pkg SHALL hold the S and Sinv nibble functions, the mode encoding constants (MODE_ENC=0, MODE_DEC=1), and the default TAPS and SEED values.
REQ-035 The LFSR and beat counter SHALL live in sub-module crypto_stream_keygen (ports: clk, rst, advance, seed_load, seed_in, key, beat_cnt); the pipeline stays in the top.

Verification (DATA_W=8, defaults)
REQ-036 Reset, encrypt 0x00, then 0x00 back-to-back with out_ready=1 -> out_data 0x7F (key 0xAC), then 0xDC (key 0x59), first result 2 cycles after accept; beat_cnt=2.
REQ-037 Reset, decrypt 0x7F then 0xDC -> 0x00, 0x00; out_mode=1.
REQ-038 Stream 256 random bytes through encrypt, reset, then decrypt the ciphertext -> the original bytes, in order.
REQ-039 Hold out_ready=0 for 3 cycles with 3 beats offered -> at most 2 beats accepted, out_data stable, no loss or duplication after release.
REQ-040 seed_load=1 with seed_in=0x00 while in_valid=1 -> in_ready=0 that cycle and the next key is 0xAC; with seed_in=0x59 -> next key is 0x59.
REQ-041 Assert rst with both stages full -> out_valid=0 next cycle, beat_cnt=0, and the next encrypt of 0x00 gives 0x7F.
